// File: rtl/qerv_bufreg_seq.sv
// qerv_bufreg_seq
// Sequencer for the W-bit-serial buffer register of the qerv core. It walks
// the buffer register through one 32-bit pass (execute only) or two passes
// (init, then execute, separated by a GAP that waits for i_go). It also
// splits the shift amount into a sub-word residue and a whole-chunk skip
// counter for the datapath.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_start              sequence request, taken only while o_ready=1
//   i_two_stage          with i_start: 1 = init + execute, 0 = execute only
//   i_shamt, i_shift_op  shift operands, latched with i_start
//   i_stall              holds the current beat
//   i_go                 releases the GAP state
//   o_ready              idle, can accept i_start
//   o_en                 beat enable to the buffer register
//   o_init               current beat belongs to the init pass
//   o_cnt0/o_cnt1        first/second beat of a pass (qualified by o_en)
//   o_cnt_done           last beat of a pass (qualified by o_en)
//   o_shift_counter_lsb  sub-word shift residue, MSB always 0
//   o_sh_done            whole-chunk skip counter has reached zero
//   o_done               one-cycle pulse after the last execute beat
module qerv_bufreg_seq #(
  parameter int W  = 4,
  parameter int LB = $clog2(W)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_two_stage,
  input  logic [4:0]  i_shamt,
  input  logic        i_shift_op,
  input  logic        i_stall,
  input  logic        i_go,
  output logic        o_ready,
  output logic        o_en,
  output logic        o_init,
  output logic        o_cnt0,
  output logic        o_cnt1,
  output logic        o_cnt_done,
  output logic [LB:0] o_shift_counter_lsb,
  output logic        o_sh_done,
  output logic        o_done
);

  localparam int CW = 5 - LB;
  localparam logic [CW-1:0] CNT_LAST = CW'(32 / W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    GAP  = 2'd2,
    EXEC = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] skip_q;
  logic          shift_op_q;
  logic          done_q;
  logic          beat_en;
  logic          cnt_last;
  logic          accept;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign accept   = (state_q == IDLE) & i_start;

  // Next-state and phase outputs. Only INIT and EXEC produce beats; IDLE and
  // GAP ignore i_stall entirely. i_go only matters while sitting in GAP.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_init  = 1'b0;
    beat_en = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          state_d = i_two_stage ? INIT : EXEC;
        end
      end
      INIT: begin
        o_init  = 1'b1;
        beat_en = ~i_stall;
        if (~i_stall && cnt_last) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (i_go) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        beat_en = ~i_stall;
        if (~i_stall && cnt_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_en       = beat_en;
  assign o_cnt0     = beat_en & (cnt_q == '0);
  assign o_cnt1     = beat_en & (cnt_q == CW'(1));
  assign o_cnt_done = beat_en & cnt_last;
  assign o_sh_done  = (skip_q == '0) | ~shift_op_q;
  assign o_done     = done_q;

  // State register and the done pulse, which marks the cycle in which the
  // FSM has just returned to IDLE from the final execute beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == EXEC) & beat_en & cnt_last;
    end
  end

  // Beat counter. Held at zero outside the passes so every pass, including
  // the one after a mid-pass reset, starts at beat 0. It wraps naturally
  // after the last beat because the count range fills its width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || state_q == GAP) begin
      cnt_q <= '0;
    end else if (beat_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Operand latch and whole-chunk skip counter. Operands are only captured
  // on an accepted start, so a start arriving mid-sequence cannot disturb
  // them. The skip counter counts execute beats only and sticks at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_op_q <= 1'b0;
      skip_q     <= '0;
    end else if (accept) begin
      shift_op_q <= i_shift_op;
      skip_q     <= i_shamt[4:LB];
    end else if ((state_q == EXEC) && beat_en && (skip_q != '0)) begin
      skip_q <= skip_q - 1'b1;
    end
  end

  generate
    if (LB > 0) begin : g_res
      logic [LB-1:0] res_q;

      // Sub-word residue of the shift amount; only the low LB bits are kept
      // since the upper bits live in the skip counter.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          res_q <= '0;
        end else if (accept) begin
          res_q <= i_shamt[LB-1:0];
        end
      end

      assign o_shift_counter_lsb = {1'b0, (shift_op_q ? res_q : {LB{1'b0}})};
    end else begin : g_nores
      assign o_shift_counter_lsb = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_qerv_bufreg_seq.sv
// Testbench for qerv_bufreg_seq (W=4). Each scenario builds its expected
// per-cycle output trace from the scenario timeline into a queue, then
// drives the DUT and pops one expected row per cycle to compare.
module tb_qerv_bufreg_seq;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_two_stage;
  logic [4:0] i_shamt;
  logic       i_shift_op;
  logic       i_stall;
  logic       i_go;
  logic       o_ready;
  logic       o_en;
  logic       o_init;
  logic       o_cnt0;
  logic       o_cnt1;
  logic       o_cnt_done;
  logic [2:0] o_shift_counter_lsb;
  logic       o_sh_done;
  logic       o_done;

  int vectors;
  int miscompares;

  // Row layout: {ready, en, init, cnt0, cnt1, cnt_done, done, sh_done, lsb[2:0]}
  logic [10:0] sb[$];

  qerv_bufreg_seq #(.W(4)) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_start             (i_start),
    .i_two_stage         (i_two_stage),
    .i_shamt             (i_shamt),
    .i_shift_op          (i_shift_op),
    .i_stall             (i_stall),
    .i_go                (i_go),
    .o_ready             (o_ready),
    .o_en                (o_en),
    .o_init              (o_init),
    .o_cnt0              (o_cnt0),
    .o_cnt1              (o_cnt1),
    .o_cnt_done          (o_cnt_done),
    .o_shift_counter_lsb (o_shift_counter_lsb),
    .o_sh_done           (o_sh_done),
    .o_done              (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [10:0] row(input bit rdy, input bit en, input bit ini,
                                      input bit c0, input bit c1, input bit cd,
                                      input bit dn, input bit sh, input logic [2:0] r);
    return {rdy, en, ini, c0, c1, cd, dn, sh, r};
  endfunction

  function automatic logic [10:0] observed();
    return {o_ready, o_en, o_init, o_cnt0, o_cnt1, o_cnt_done, o_done,
            o_sh_done, o_shift_counter_lsb};
  endfunction

  // Expected trace from cycle 1 (first cycle after the start is sampled):
  // optional init pass, GAP until i_go is seen, execute pass, done cycle,
  // then two quiet idle cycles.
  task automatic build_expected(input bit two, input logic [4:0] shamt, input bit sop,
                                input int stall_from, input int stall_len, input int go_from);
    int c;
    int skip;
    bit last;
    logic [2:0] r;
    r = sop ? {1'b0, shamt[1:0]} : 3'b000;
    skip = int'(shamt) / 4;
    c = 1;
    if (two) begin
      for (int b = 0; b < 8; b++) begin
        while (c >= stall_from && c < stall_from + stall_len) begin
          sb.push_back(row(0, 0, 1, 0, 0, 0, 0, (skip == 0) || !sop, r));
          c++;
        end
        sb.push_back(row(0, 1, 1, b == 0, b == 1, b == 7, 0, (skip == 0) || !sop, r));
        c++;
      end
      forever begin
        sb.push_back(row(0, 0, 0, 0, 0, 0, 0, (skip == 0) || !sop, r));
        last = (c >= go_from);
        c++;
        if (last) break;
      end
    end
    for (int b = 0; b < 8; b++) begin
      while (c >= stall_from && c < stall_from + stall_len) begin
        sb.push_back(row(0, 0, 0, 0, 0, 0, 0, (skip == 0) || !sop, r));
        c++;
      end
      sb.push_back(row(0, 1, 0, b == 0, b == 1, b == 7, 0, (skip == 0) || !sop, r));
      if (skip > 0) skip--;
      c++;
    end
    sb.push_back(row(1, 0, 0, 0, 0, 0, 1, (skip == 0) || !sop, r));
    sb.push_back(row(1, 0, 0, 0, 0, 0, 0, (skip == 0) || !sop, r));
    sb.push_back(row(1, 0, 0, 0, 0, 0, 0, (skip == 0) || !sop, r));
  endtask

  // Issues one start, then per cycle drives stall/go (and an optional stray
  // start at cycle inj_cycle) and compares against the queued trace.
  task automatic run_seq(input string name, input bit two, input logic [4:0] shamt,
                         input bit sop, input int stall_from, input int stall_len,
                         input int go_from, input int inj_cycle, input logic [4:0] inj_shamt);
    int c;
    logic [10:0] exp_row;
    logic [10:0] act;
    build_expected(two, shamt, sop, stall_from, stall_len, go_from);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_two_stage = two;
    i_shamt = shamt;
    i_shift_op = sop;
    i_stall = 1'b0;
    i_go = 1'b0;
    c = 0;
    while (sb.size() > 0) begin
      @(posedge i_clk); #1;
      c++;
      i_start = (c == inj_cycle);
      if (c == inj_cycle) begin
        i_shamt = inj_shamt;
        i_shift_op = ~sop;
        i_two_stage = ~two;
      end
      i_stall = (c >= stall_from) && (c < stall_from + stall_len);
      i_go = (c >= go_from);
      @(negedge i_clk);
      exp_row = sb.pop_front();
      act = observed();
      vectors++;
      if (act !== exp_row) begin
        miscompares++;
        $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, c, act, exp_row);
      end
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    i_go = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] act;
    i_rst_n = 1'b0;
    #3;
    act = observed();
    vectors++;
    if (act !== row(1, 0, 0, 0, 0, 0, 0, 1, 3'b000)) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b expected %b", act, row(1, 0, 0, 0, 0, 0, 0, 1, 3'b000));
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_single_stage();
    run_seq("single_stage", 1'b0, 5'd0, 1'b0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_two_stage();
    run_seq("two_stage", 1'b1, 5'd0, 1'b0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_stall_and_gap();
    // Init beats 1-3, stall cycles 4-6, beats resume at counter 3 on cycle 7,
    // GAP starts on cycle 12 and i_go first seen on cycle 16.
    run_seq("stall_gap", 1'b1, 5'd0, 1'b0, 4, 3, 16, 0, 5'd0);
    run_seq("exec_stall_first_beat", 1'b0, 5'd9, 1'b1, 1, 2, 0, 0, 5'd0);
  endtask

  task automatic test_shift();
    run_seq("shift_13", 1'b0, 5'd13, 1'b1, 0, 0, 0, 0, 5'd0);
    run_seq("shift_3", 1'b0, 5'd3, 1'b1, 0, 0, 0, 0, 5'd0);
    run_seq("shift_31_two_stage", 1'b1, 5'd31, 1'b1, 0, 0, 0, 0, 5'd0);
    run_seq("shift_op_off", 1'b0, 5'd13, 1'b0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_reset_mid_pass();
    logic [10:0] act;
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_two_stage = 1'b0;
    i_shamt = 5'd13;
    i_shift_op = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    vectors++;
    if (o_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_pass_running: o_en got %b expected 1", o_en);
    end
    i_rst_n = 1'b0;
    #1;
    act = observed();
    vectors++;
    if (act !== row(1, 0, 0, 0, 0, 0, 0, 1, 3'b000)) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_pass: got %b expected %b", act, row(1, 0, 0, 0, 0, 0, 0, 1, 3'b000));
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      vectors++;
      if (o_done !== 1'b0 || o_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL no_done_after_reset cycle %0d: done %b ready %b expected done 0 ready 1",
                 k, o_done, o_ready);
      end
    end
    run_seq("start_after_reset", 1'b0, 5'd5, 1'b1, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_start_ignored();
    run_seq("start_during_init", 1'b1, 5'd13, 1'b1, 0, 0, 0, 4, 5'd6);
    run_seq("start_during_exec", 1'b0, 5'd7, 1'b1, 0, 0, 0, 3, 5'd28);
  endtask

  task automatic test_back_to_back();
    run_seq("back_to_back_a", 1'b0, 5'd4, 1'b1, 0, 0, 0, 0, 5'd0);
    run_seq("back_to_back_b", 1'b1, 5'd2, 1'b1, 10, 1, 0, 0, 5'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_two_stage = 1'b0;
    i_shamt = 5'd0;
    i_shift_op = 1'b0;
    i_stall = 1'b0;
    i_go = 1'b0;
    test_reset();
    test_single_stage();
    test_two_stage();
    test_stall_and_gap();
    test_shift();
    test_reset_mid_pass();
    test_start_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
